// File: rtl/simon_cfg_pkg.sv
// Shared constants, state encodings and the key-length legality check for the
// Simon key-schedule configuration slave.
package simon_cfg_pkg;

   localparam logic [7:0] KEY_BASE   = 8'h00;
   localparam logic [7:0] CTRL_OFS   = 8'h40;
   localparam logic [7:0] STATUS_OFS = 8'h44;

   localparam int CTRL_START    = 0;
   localparam int CTRL_AUTO     = 1;
   localparam int CTRL_CLR      = 2;
   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_FILL_LSB = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   function automatic bit keylen_legal(input int bits);
      return (bits == 64) || (bits == 72) || (bits == 96) || (bits == 128) ||
             (bits == 144) || (bits == 192) || (bits == 256);
   endfunction

endpackage

// File: rtl/simon_axil_cfg_axil_reg_if.sv
// AXI4-Lite handshake engine: turns AW/W/B and AR/R traffic into a one-cycle
// write strobe and a combinational read lookup against the register file.
module axil_reg_if
   import simon_cfg_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [31:0]           s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [31:0]           s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  wr_en,
   output logic [7:0]            wr_addr,
   output logic [31:0]           wr_data,
   output logic [3:0]            wr_strb,
   input  logic                  wr_err,
   output logic [7:0]            rd_addr,
   input  logic [31:0]           rd_data,
   input  logic                  rd_err
);

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic [7:0]  awaddr_q, awaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        aw_hs, w_hs, rd_en;

   assign s_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
   assign s_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
   assign s_bvalid  = (w_state_q == W_RESP);
   assign s_bresp   = bresp_q;
   assign s_arready = (r_state_q == R_IDLE);
   assign s_rvalid  = (r_state_q == R_RESP);
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

   assign aw_hs = s_awvalid && s_awready;
   assign w_hs  = s_wvalid && s_wready;

   // Commit happens on the edge that supplies the last missing half.
   assign wr_en   = (aw_hs || (w_state_q == W_HAVE_A)) && (w_hs || (w_state_q == W_HAVE_D));
   assign wr_addr = (w_state_q == W_HAVE_A) ? awaddr_q : s_awaddr[7:0];
   assign wr_data = (w_state_q == W_HAVE_D) ? wdata_q : s_wdata;
   assign wr_strb = (w_state_q == W_HAVE_D) ? wstrb_q : s_wstrb;

   assign rd_en   = s_arvalid && s_arready;
   assign rd_addr = s_araddr[7:0];

   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_IDLE: begin
            if (wr_en) begin
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               w_state_d = W_HAVE_A;
               awaddr_d  = s_awaddr[7:0];
            end else if (w_hs) begin
               w_state_d = W_HAVE_D;
               wdata_d   = s_wdata;
               wstrb_d   = s_wstrb;
            end
         end
         W_HAVE_A, W_HAVE_D: if (wr_en) w_state_d = W_RESP;
         W_RESP:             if (s_bready) w_state_d = W_IDLE;
         default:            w_state_d = W_IDLE;
      endcase
      if (wr_en) bresp_d = wr_err ? RESP_SLVERR : RESP_OKAY;
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (rd_en) begin
         r_state_d = R_RESP;
         rdata_d   = rd_data;
         rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if ((r_state_q == R_RESP) && s_rready) begin
         r_state_d = R_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

// File: rtl/simon_axil_cfg.sv
// AXI4-Lite configuration slave for the Simon key schedule: key storage with
// fill tracking, manual/automatic start pulses and sticky completion status.
module simon_axil_cfg
   import simon_cfg_pkg::*;
#(
   parameter int KEYLEN_BITS = 256,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  s_awaddr,
   input  logic                   s_awvalid,
   output logic                   s_awready,
   input  logic [31:0]            s_wdata,
   input  logic [3:0]             s_wstrb,
   input  logic                   s_wvalid,
   output logic                   s_wready,
   output logic [1:0]             s_bresp,
   output logic                   s_bvalid,
   input  logic                   s_bready,
   input  logic [ADDR_WIDTH-1:0]  s_araddr,
   input  logic                   s_arvalid,
   output logic                   s_arready,
   output logic [31:0]            s_rdata,
   output logic [1:0]             s_rresp,
   output logic                   s_rvalid,
   input  logic                   s_rready,
   output logic [KEYLEN_BITS-1:0] init_key,
   output logic                   key_compute_start,
   input  logic                   key_busy,
   input  logic                   key_done
);

   localparam int KEY_WORDS = (KEYLEN_BITS + 31) / 32;
   localparam int LAST_BITS = KEYLEN_BITS - 32 * (KEY_WORDS - 1);
   localparam logic [31:0] LAST_MASK =
      (LAST_BITS == 32) ? 32'hFFFF_FFFF : ((32'h1 << LAST_BITS) - 32'h1);

   if (!keylen_legal(KEYLEN_BITS)) begin : g_bad_keylen
      $error("simon_axil_cfg: unsupported KEYLEN_BITS");
   end

   logic                    wr_en, wr_err, rd_err;
   logic [7:0]              wr_addr, rd_addr, wr_ofs, rd_ofs;
   logic [5:0]              wr_idx, rd_idx;
   logic [31:0]             wr_data, rd_data;
   logic [3:0]              wr_strb;
   logic                    wr_is_key, wr_is_ctrl, wr_is_stat;
   logic                    rd_is_key, rd_is_ctrl, rd_is_stat;
   logic [31:0]             key_q [KEY_WORDS];
   logic [31:0]             key_d [KEY_WORDS];
   logic [KEY_WORDS-1:0]    fill_q, fill_d;
   logic                    auto_q, auto_d, done_q, done_d, start_q, start_d;
   logic                    auto_fire, start_cmd;
   logic [32*KEY_WORDS-1:0] key_flat;

   axil_reg_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_err(wr_err), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
   );

   assign wr_ofs     = wr_addr & 8'hFC;
   assign rd_ofs     = rd_addr & 8'hFC;
   assign wr_idx     = wr_ofs[7:2] - KEY_BASE[7:2];
   assign rd_idx     = rd_ofs[7:2] - KEY_BASE[7:2];
   assign wr_is_key  = (wr_ofs - KEY_BASE) < 8'(4 * KEY_WORDS);
   assign rd_is_key  = (rd_ofs - KEY_BASE) < 8'(4 * KEY_WORDS);
   assign wr_is_ctrl = (wr_ofs == CTRL_OFS);
   assign rd_is_ctrl = (rd_ofs == CTRL_OFS);
   assign wr_is_stat = (wr_ofs == STATUS_OFS);
   assign rd_is_stat = (rd_ofs == STATUS_OFS);
   assign wr_err     = !(wr_is_key || wr_is_ctrl || wr_is_stat);
   assign rd_err     = !(rd_is_key || rd_is_ctrl || rd_is_stat);

   always_comb begin
      key_d     = key_q;
      fill_d    = fill_q;
      auto_d    = auto_q;
      done_d    = done_q;
      start_cmd = 1'b0;
      auto_fire = auto_q && (&fill_q) && !key_busy;
      if (auto_fire) fill_d = '0;
      // CLR is applied before the key write path so START+CLR still pulses.
      if (wr_en && wr_is_ctrl && wr_strb[0]) begin
         auto_d    = wr_data[CTRL_AUTO];
         start_cmd = wr_data[CTRL_START] && !key_busy;
         if (wr_data[CTRL_CLR]) begin
            for (int i = 0; i < KEY_WORDS; i++) key_d[i] = '0;
            fill_d = '0;
         end
      end
      if (wr_en && wr_is_key && (wr_strb != 4'b0000)) begin
         for (int i = 0; i < KEY_WORDS; i++) begin
            if (wr_idx == 6'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) key_d[i][8*b +: 8] = wr_data[8*b +: 8];
               end
               key_d[i]  = key_d[i] & ((i == KEY_WORDS - 1) ? LAST_MASK : 32'hFFFF_FFFF);
               fill_d[i] = 1'b1;
            end
         end
      end
      if (wr_en && wr_is_stat && wr_strb[0] && wr_data[STAT_DONE]) done_d = 1'b0;
      start_d = auto_fire || start_cmd;
      if (start_d) done_d = 1'b0;
      if (key_done) done_d = 1'b1;
   end

   always_comb begin
      rd_data = '0;
      if (rd_is_key) begin
         for (int i = 0; i < KEY_WORDS; i++) begin
            if (rd_idx == 6'(i)) rd_data = key_q[i];
         end
      end else if (rd_is_ctrl) begin
         rd_data[CTRL_AUTO] = auto_q;
      end else if (rd_is_stat) begin
         rd_data[STAT_BUSY]            = key_busy;
         rd_data[STAT_DONE]            = done_q;
         rd_data[STAT_FILL_LSB +: 8]   = 8'(fill_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
         fill_q  <= '0;
         auto_q  <= 1'b1;
         done_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         key_q   <= key_d;
         fill_q  <= fill_d;
         auto_q  <= auto_d;
         done_q  <= done_d;
         start_q <= start_d;
      end
   end

   for (genvar g = 0; g < KEY_WORDS; g++) begin : g_flat
      assign key_flat[32*g +: 32] = key_q[g];
   end

   assign init_key          = key_flat[KEYLEN_BITS-1:0];
   assign key_compute_start = start_q;

endmodule

// File: tb/tb_simon_axil_cfg.sv
// Directed bench: a 128-bit and a 72-bit instance share all inputs; sel72
// picks which instance's outputs the transaction tasks observe.
module tb_simon_axil_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        key_busy = 0, key_done = 0;
   logic        sel72 = 0;

   logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, start_a;
   logic [1:0]  bresp_a, rresp_a;
   logic [31:0] rdata_a;
   logic [127:0] key_a;
   logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, start_b;
   logic [1:0]  bresp_b, rresp_b;
   logic [31:0] rdata_b;
   logic [71:0] key_b;

   logic        awready, wready, bvalid, arready, rvalid, start;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   assign awready = sel72 ? awready_b : awready_a;
   assign wready  = sel72 ? wready_b  : wready_a;
   assign bvalid  = sel72 ? bvalid_b  : bvalid_a;
   assign arready = sel72 ? arready_b : arready_a;
   assign rvalid  = sel72 ? rvalid_b  : rvalid_a;
   assign start   = sel72 ? start_b   : start_a;
   assign bresp   = sel72 ? bresp_b   : bresp_a;
   assign rresp   = sel72 ? rresp_b   : rresp_a;
   assign rdata   = sel72 ? rdata_b   : rdata_a;

   int   checks = 0, bad = 0, pulses_a = 0;
   logic start_e1, start_e2;
   logic done_on_commit = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (start_a === 1'b1) pulses_a++;

   simon_axil_cfg #(.KEYLEN_BITS(128), .ADDR_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst),
      .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready_a),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready_a),
      .s_bresp(bresp_a), .s_bvalid(bvalid_a), .s_bready(bready),
      .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready_a),
      .s_rdata(rdata_a), .s_rresp(rresp_a), .s_rvalid(rvalid_a), .s_rready(rready),
      .init_key(key_a), .key_compute_start(start_a),
      .key_busy(key_busy), .key_done(key_done)
   );

   simon_axil_cfg #(.KEYLEN_BITS(72), .ADDR_WIDTH(8)) dut_b (
      .clk(clk), .rst(rst),
      .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready_b),
      .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready_b),
      .s_bresp(bresp_b), .s_bvalid(bvalid_b), .s_bready(bready),
      .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready_b),
      .s_rdata(rdata_b), .s_rresp(rresp_b), .s_rvalid(rvalid_b), .s_rready(rready),
      .init_key(key_b), .key_compute_start(start_b),
      .key_busy(key_busy), .key_done(key_done)
   );

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int   n = 0;
      logic aw_acc, w_acc;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
      while ((awvalid || wvalid) && n < 20) begin
         aw_acc = awvalid && awready;
         w_acc  = wvalid && wready;
         if (done_on_commit && (aw_acc || !awvalid) && (w_acc || !wvalid)) key_done = 1;
         @(posedge clk); #1;
         key_done = 0;
         if (aw_acc) awvalid = 0;
         if (w_acc) wvalid = 0;
         n++;
      end
      start_e1 = start;
      n = 0;
      while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (bvalid !== 1'b1) begin
         bad++;
         $display("FAIL write_bvalid addr=%h: got bvalid=%b want 1", a, bvalid);
         awvalid = 0; wvalid = 0; resp = 2'bxx;
         return;
      end
      resp = bresp;
      @(posedge clk); #1;
      start_e2 = start;
   endtask

   task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      araddr = a; arvalid = 1; rready = 1;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      arvalid = 0;
      checks++;
      if (rvalid !== 1'b1) begin
         bad++;
         $display("FAIL read_rvalid addr=%h: got rvalid=%b want 1", a, rvalid);
         d = 'x; r = 'x;
         return;
      end
      d = rdata; r = rresp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic [1:0] rr;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      checks++; if ({bvalid, rvalid, start} !== 3'b000) begin bad++; $display("FAIL rst_valids: got %b want 000", {bvalid, rvalid, start}); end
      checks++; if ({awready, wready, arready} !== 3'b111) begin bad++; $display("FAIL rst_readys: got %b want 111", {awready, wready, arready}); end
      checks++; if ({bresp, rresp, rdata} !== 36'h0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", {bresp, rresp, rdata}); end
      checks++; if (key_a !== 128'h0) begin bad++; $display("FAIL rst_key: got %h want 0", key_a); end
      axi_read(8'h40, rd, rr);
      checks++; if ({rr, rd} !== {2'b00, 32'h2}) begin bad++; $display("FAIL rst_ctrl: got %h/%b want 00000002/00", rd, rr); end
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", rd); end
   endtask

   task automatic test_auto_key();
      logic [31:0] rd; logic [1:0] rr; int base;
      base = pulses_a;
      axi_write(8'h00, 32'h03020100, 4'hF, rr);
      checks++; if (rr !== 2'b00) begin bad++; $display("FAIL key0_bresp: got %b want 00", rr); end
      axi_write(8'h04, 32'h07060504, 4'hF, rr);
      axi_write(8'h08, 32'h0B0A0908, 4'hF, rr);
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0000_0700) begin bad++; $display("FAIL fill_three: got %h want 00000700", rd); end
      axi_write(8'h0C, 32'h0F0E0D0C, 4'hF, rr);
      checks++; if ({start_e1, start_e2} !== 2'b01) begin bad++; $display("FAIL auto_timing: got e1e2=%b want 01", {start_e1, start_e2}); end
      repeat (3) @(posedge clk); #1;
      checks++; if (pulses_a - base !== 1) begin bad++; $display("FAIL auto_count: got %0d want 1", pulses_a - base); end
      checks++; if (key_a !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin bad++; $display("FAIL init_key128: got %h want 0f0e0d0c0b0a090807060504030201 00", key_a); end
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL fill_cleared: got %h want 0", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic [1:0] rr; int ok;
      bready = 0; awaddr = 8'h04; awvalid = 1; wvalid = 0;
      @(posedge clk); #1; awvalid = 0;
      checks++; if ({awready, wready} !== 2'b01) begin bad++; $display("FAIL have_a_readys: got %b want 01", {awready, wready}); end
      repeat (2) @(posedge clk); #1;
      wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
      @(posedge clk); #1; wvalid = 0;
      awaddr = 8'h08; wdata = 32'h5A5A5A5A; awvalid = 1; wvalid = 1;
      ok = 1;
      for (int i = 0; i < 4; i++) begin
         if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0)) ok = 0;
         @(posedge clk); #1;
      end
      awvalid = 0; wvalid = 0;
      checks++; if (ok !== 1) begin bad++; $display("FAIL b_hold: got ok=%0d want 1", ok); end
      bready = 1; @(posedge clk); #1;
      checks++; if (bvalid !== 1'b0) begin bad++; $display("FAIL b_release: got %b want 0", bvalid); end
      axi_read(8'h04, rd, rr);
      checks++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL bp_key1: got %h want a5a5a5a5", rd); end
      axi_read(8'h08, rd, rr);
      checks++; if (rd !== 32'h0B0A0908) begin bad++; $display("FAIL bp_key2: got %h want 0b0a0908", rd); end
   endtask

   task automatic test_ctrl_start_done();
      logic [31:0] rd; logic [1:0] rr; int base;
      axi_write(8'h40, 32'h4, 4'hF, rr);
      axi_read(8'h00, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_key0: got %h want 0", rd); end
      axi_read(8'h40, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL auto_off: got %h want 0", rd); end
      key_busy = 1; base = pulses_a;
      axi_write(8'h40, 32'h1, 4'hF, rr);
      checks++; if (rr !== 2'b00) begin bad++; $display("FAIL busy_start_bresp: got %b want 00", rr); end
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h1) begin bad++; $display("FAIL status_busy: got %h want 1", rd); end
      checks++; if (pulses_a - base !== 0) begin bad++; $display("FAIL busy_dropped: got %0d pulses want 0", pulses_a - base); end
      key_busy = 0;
      axi_write(8'h40, 32'h1, 4'hF, rr);
      checks++; if ({start_e1, start_e2} !== 2'b10) begin bad++; $display("FAIL start_timing: got e1e2=%b want 10", {start_e1, start_e2}); end
      key_done = 1; @(posedge clk); #1; key_done = 0;
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h2) begin bad++; $display("FAIL done_set: got %h want 2", rd); end
      axi_write(8'h44, 32'h2, 4'hF, rr);
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL done_w1c: got %h want 0", rd); end
      done_on_commit = 1;
      axi_write(8'h44, 32'h2, 4'hF, rr);
      done_on_commit = 0;
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h2) begin bad++; $display("FAIL done_set_wins: got %h want 2", rd); end
      axi_write(8'h00, 32'h12345678, 4'hF, rr);
      axi_write(8'h40, 32'h5, 4'hF, rr);
      checks++; if (start_e1 !== 1'b1) begin bad++; $display("FAIL clr_start_pulse: got %b want 1", start_e1); end
      axi_read(8'h00, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_start_key0: got %h want 0", rd); end
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_start_status: got %h want 0", rd); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] rd; logic [1:0] rr;
      axi_write(8'h04, 32'h11111111, 4'hF, rr);
      awaddr = 8'h04; wdata = 32'h22222222; wstrb = 4'hF; araddr = 8'h04;
      awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      checks++; if ({rvalid, bvalid, rdata} !== {2'b11, 32'h11111111}) begin bad++; $display("FAIL same_edge_old: got v=%b data=%h want 11/11111111", {rvalid, bvalid}, rdata); end
      @(posedge clk); #1;
      axi_read(8'h04, rd, rr);
      checks++; if (rd !== 32'h22222222) begin bad++; $display("FAIL same_edge_new: got %h want 22222222", rd); end
   endtask

   task automatic test_keylen72();
      logic [31:0] rd; logic [1:0] rr;
      sel72 = 1;
      axi_write(8'h08, 32'hFFFFFFFF, 4'b0101, rr);
      checks++; if (rr !== 2'b00) begin bad++; $display("FAIL k72_bresp: got %b want 00", rr); end
      axi_read(8'h08, rd, rr);
      checks++; if ({rr, rd} !== {2'b00, 32'h000000FF}) begin bad++; $display("FAIL k72_key2: got %h/%b want 000000ff/00", rd, rr); end
      checks++; if (key_b[71:64] !== 8'hFF) begin bad++; $display("FAIL k72_init_key: got %h want ff", key_b[71:64]); end
      axi_write(8'h0C, 32'h12345678, 4'hF, rr);
      checks++; if (rr !== 2'b10) begin bad++; $display("FAIL k72_wr_slverr: got %b want 10", rr); end
      axi_read(8'h0C, rd, rr);
      checks++; if ({rr, rd} !== {2'b10, 32'h0}) begin bad++; $display("FAIL k72_rd_slverr: got %h/%b want 00000000/10", rd, rr); end
      axi_write(8'h00, 32'hDEADBEEF, 4'h0, rr);
      checks++; if (rr !== 2'b00) begin bad++; $display("FAIL strb0_bresp: got %b want 00", rr); end
      axi_read(8'h00, rd, rr);
      checks++; if (rd !== 32'h0) begin bad++; $display("FAIL strb0_key0: got %h want 0", rd); end
      axi_read(8'h44, rd, rr);
      checks++; if (rd !== 32'h0000_0600) begin bad++; $display("FAIL k72_fill: got %h want 00000600", rd); end
      sel72 = 0;
   endtask

   task automatic test_reset_midflight();
      logic [31:0] rd; logic [1:0] rr;
      awaddr = 8'h00; awvalid = 1; wvalid = 0; araddr = 8'h04; arvalid = 1; rready = 0; bready = 0;
      @(posedge clk); #1;
      awvalid = 0; arvalid = 0;
      checks++; if ({awready, wready, rvalid} !== 3'b011) begin bad++; $display("FAIL pre_rst_state: got %b want 011", {awready, wready, rvalid}); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin bad++; $display("FAIL mid_rst_hs: got %b want 00111", {bvalid, rvalid, awready, wready, arready}); end
      checks++; if (key_a !== 128'h0) begin bad++; $display("FAIL mid_rst_key: got %h want 0", key_a); end
      rready = 1; bready = 1;
      axi_read(8'h40, rd, rr);
      checks++; if (rd !== 32'h2) begin bad++; $display("FAIL mid_rst_auto: got %h want 2", rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_auto_key();
      test_backpressure();
      test_ctrl_start_done();
      test_simultaneous();
      test_keylen72();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
   end

endmodule

// File: doc/simon_axil_cfg.md
# simon_axil_cfg

Parametrised AXI4-Lite configuration slave for the Simon key schedule, supporting every Simon key length from 64 to 256 bits. It holds the initial key, tracks which key words have been written, and issues start pulses to the key-expansion engine, either automatically or on command. It also reports engine busy/done status. It sits between the host AXI-Lite interconnect and the key-schedule core, with full AXI-Lite handshaking (backpressure, strobes, error responses).

## Interface
- KEYLEN_BITS, 256, Simon key length; legal values 64, 72, 96, 128, 144, 192, 256
- ADDR_WIDTH, 8, AXI-Lite address width; only bits [7:0] are decoded
- KEY_WORDS (derived, localparam), ceil(KEYLEN_BITS/32), number of 32-bit key registers
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- s_awaddr / s_awvalid / s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp / s_bvalid / s_bready  out/out/in  2/1/1  write response channel
- s_araddr / s_arvalid / s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  32/2/1/1  read data channel
- init_key  out  KEYLEN_BITS  key; word i drives bits [32i+31:32i]
- key_compute_start  out  1  one-cycle start pulse to the key schedule
- key_busy  in  1  key schedule running
- key_done  in  1  one-cycle completion pulse

## Operation
- Register map (byte offsets; addr[1:0] ignored):
  - KEY[i] at 0x00+4i, i < KEY_WORDS, RW.
  - CTRL at 0x40: bit0 START (W, reads 0); bit1 AUTO (RW, reset 1); bit2 CLR (W, reads 0).
  - STATUS at 0x44, RO: bit0 = key_busy; bit1 = DONE (sticky, W1C via a write to 0x44); bits[15:8] = fill mask, zero-extended.
  - Any other offset: writes have no effect and return SLVERR (2'b10); reads return 0 with SLVERR. Legal accesses return OKAY.
- Key writes honour s_wstrb per byte.
  - For KEYLEN_BITS not a multiple of 32 (72, 144), last-word bits at or above KEYLEN_BITS mod 32 are not stored and read as 0.
  - A key write with nonzero strobe sets fill bit i. A write with wstrb=0 changes nothing and returns OKAY.
- START=1 pulses key_compute_start if key_busy=0. If key_busy=1 it is dropped, and the write still returns OKAY.
- CLR=1 zeroes all key words and the fill mask. If START and CLR are written together, CLR applies first and START still pulses.
- Auto-start: fires when AUTO=1, the fill mask is all-ones and key_busy=0.
  - It pulses key_compute_start and clears the fill mask.
  - While key_busy=1, a full mask waits and fires the first cycle busy is low.
- Any start pulse clears DONE. key_done sets DONE. If key_done and a DONE W1C happen in the same cycle, the set wins.
- Write FSM: W_IDLE -> (AW only) W_HAVE_A / (W only) W_HAVE_D / (both) W_RESP.
  - W_HAVE_A or W_HAVE_D -> W_RESP when the missing half arrives.
  - W_RESP -> W_IDLE on s_bready.
  - s_awready is high only in W_IDLE and W_HAVE_D. s_wready is high only in W_IDLE and W_HAVE_A.
- Read FSM: R_IDLE (s_arready=1) -> R_RESP on s_arvalid; R_RESP -> R_IDLE on s_rready.
  - s_rdata and s_rresp are held stable while s_rvalid=1.

## Timing
- Reset values:
  - All key words, fill mask, DONE, s_bvalid, s_rvalid, s_rdata, s_bresp, s_rresp and key_compute_start are 0. AUTO is 1.
  - s_awready, s_wready and s_arready are 1 in the cycle after reset.
  - Reset mid-transaction abandons it with no response.
- Commit edge E is the edge completing both AW and W.
  - In cycle E+1: register updated, s_bvalid=1, and a START pulse if requested.
  - An auto-start pulse comes one cycle later, in E+2. The fill mask reads 0 from E+3.
- Read: AR accepted at edge A gives s_rvalid=1 with data in cycle A+1.
  - Data is sampled at A. A read accepted on the same edge as a write commit returns the old value.
- The write and read FSMs are independent; both channels may complete on the same edge.
- Throughput: one write per 2 cycles and one read per 2 cycles when bready/rready are held high.

## Structure
- Package simon_cfg_pkg:
  - Offsets KEY_BASE, CTRL_OFS, STATUS_OFS and the CTRL/STATUS bit positions.
  - RESP_OKAY / RESP_SLVERR constants.
  - Legal-key-length check function; instantiating with an illegal KEYLEN_BITS is an elaboration error.
  - Write and read FSM state enums.
- Sub-module axil_reg_if: the AW/W/B/AR/R handshake FSMs. It presents a one-cycle write strobe (addr, data, strb) and a read request (addr), and accepts read data plus an error flag from the register file.

## Test plan
- KEYLEN_BITS=128, AUTO=1: write KEY0..KEY3 with 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> init_key=0x0F0E..0100, exactly one key_compute_start pulse 2 cycles after the last commit, fill mask 0 afterwards.
- AW presented 3 cycles before W, with s_bready held low for 4 cycles -> single commit, s_bvalid held with bresp=OKAY, no new AW/W accepted until B completes.
- KEYLEN_BITS=72: write 0xFFFFFFFF to KEY2 with wstrb=4'b0101 -> KEY2 reads 0x000000FF; a write to 0x0C returns SLVERR and its read returns 0/SLVERR.
- AUTO=0, key_busy=1: write CTRL=0x1 -> no pulse. Drop busy and write CTRL=0x1 again -> pulse in E+1. Pulse key_done and write STATUS=0x2 on the same cycle -> DONE reads 1.
- Simultaneous read and write of KEY1 (old 0x11111111, new 0x22222222) -> rdata=0x11111111; a subsequent read gives 0x22222222.
- Assert rst while s_rvalid=1 and in W_HAVE_A -> next cycle all valids 0, all readys 1, key zero, AUTO=1.
